// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the keyboard event path (and the future mouse path).
//   key_event_t    : one decoded key event as stored in the FIFO and shown to the CPU
//   KEY_TOGGLE_BIT : bit of the hps_io ps2_key word that flips once per new key event
package ps2_pkg;

    typedef struct packed {
        logic       pressed;
        logic       extended;
        logic [7:0] code;
    } key_event_t;

    localparam int unsigned KEY_TOGGLE_BIT = 10;

endpackage

// File: rtl/fifo_sync.sv
// Generic show-ahead synchronous FIFO with register storage (no read latency).
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push, din  : write request and data; accepted when not full, or when full and popping
//   pop        : read request; ignored while empty
//   dout       : mem[rd_ptr], valid only while !empty
//   count      : number of stored entries (0 .. 2**DEPTH_LOG2)
//   full/empty : count at capacity / count at zero
module fifo_sync #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  pop_ok, push_ok;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
        pop_ok  = pop & ~empty;
        // A full FIFO can still accept a write when the head leaves in the same cycle.
        push_ok = push & (~full | pop_ok);

        wr_ptr_d = push_ok ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        count_d  = count_q + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(pop_ok);

        dout  = mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; empty/count gate its visibility.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/ps2_key_fifo.sv
// Keyboard event buffer between hps_io and the CPU keyboard port.
//   clk_sys  : system clock, rising edge
//   reset    : synchronous active-high reset; discards entries and re-arms the toggle detector
//   ps2_key  : [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode
//   rd       : pop the head event (ignored while empty)
//   clr_ovf  : clear the sticky overflow flag (a same-cycle drop wins)
//   dout     : head event {pressed, extended, code}, zero while empty
//   empty/full/count : FIFO status
//   overflow : sticky, set when an event was dropped because the FIFO was full
module ps2_key_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [10:0]         ps2_key,
    input  logic                rd,
    input  logic                clr_ovf,
    output logic [9:0]          dout,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow
);

    logic       armed_q, armed_d;
    logic       toggle_q, toggle_d;
    logic       overflow_q, overflow_d;
    logic       push_req, pop_ok, drop;
    key_event_t key_in;
    key_event_t fifo_dout;

    always_comb begin
        key_in   = key_event_t'(ps2_key[9:0]);
        toggle_d = ps2_key[KEY_TOGGLE_BIT];
        // The first non-reset cycle only captures the current toggle level, so a
        // stale strobe at power-up or after reset never becomes a key event.
        armed_d  = 1'b1;
        push_req = armed_q & (ps2_key[KEY_TOGGLE_BIT] != toggle_q);
        pop_ok   = rd & ~empty;
        drop     = push_req & full & ~pop_ok;

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        dout     = empty ? '0 : fifo_dout;
        overflow = overflow_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            armed_q    <= 1'b0;
            toggle_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            armed_q    <= armed_d;
            toggle_q   <= toggle_d;
            overflow_q <= overflow_d;
        end
    end

    fifo_sync #(
        .WIDTH      ($bits(key_event_t)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk_sys),
        .reset (reset),
        .push  (push_req),
        .din   (key_in),
        .pop   (rd),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_ps2_key_fifo.sv
module tb_ps2_key_fifo;

    localparam int unsigned DL = 4;
    localparam int unsigned DEPTH = 1 << DL;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic [10:0]   ps2_key;
    logic          rd;
    logic          clr_ovf;
    logic [9:0]    dout;
    logic          empty;
    logic          full;
    logic [DL:0]   count;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    ps2_key_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_key  (ps2_key),
        .rd       (rd),
        .clr_ovf  (clr_ovf),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of events plus armed/toggle/overflow state.
    logic [9:0] mq[$];
    bit         m_armed = 0;
    bit         m_tog = 0;
    bit         m_ovf = 0;
    bit         m_valid = 0;

    always @(posedge clk_sys) begin
        bit req, pop, was_full;
        if (reset) begin
            mq.delete();
            m_armed = 0;
            m_ovf   = 0;
            m_valid = 1;
        end else begin
            req      = m_armed && (ps2_key[10] != m_tog);
            was_full = (mq.size() == DEPTH);
            pop      = rd && (mq.size() != 0);
            if (pop) void'(mq.pop_front());
            if (req && (!was_full || pop)) mq.push_back(ps2_key[9:0]);
            if (req && was_full && !pop) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            m_tog   = ps2_key[10];
            m_armed = 1;
        end
    end

    always @(negedge clk_sys) begin
        if (m_valid) begin
            check("count", int'(count), mq.size());
            check("empty", int'(empty), int'(mq.size() == 0));
            check("full", int'(full), int'(mq.size() == DEPTH));
            check("overflow", int'(overflow), int'(m_ovf));
            check("dout", int'(dout), (mq.size() != 0) ? int'(mq[0]) : 0);
        end
    end

    task automatic tick(input logic r, input logic c);
        rd      = r;
        clr_ovf = c;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic toggle(input logic [7:0] code);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, code};
    endtask

    initial begin
        reset   = 1'b1;
        ps2_key = 11'h41C;
        rd      = 1'b0;
        clr_ovf = 1'b0;
        tick(0, 0);
        tick(0, 0);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_dout", int'(dout), 0);
        check("rst_ovf", int'(overflow), 0);
        reset = 1'b0;

        // T1: toggle level high from the start must not create an event
        for (int i = 0; i < 10; i++) tick(0, 0);
        check("t1_count", int'(count), 0);
        check("t1_empty", int'(empty), 1);

        // T2: single event then pop
        ps2_key = 11'h21C;
        tick(0, 0);
        check("t2_count", int'(count), 1);
        check("t2_dout", int'(dout), 'h21C);
        tick(1, 0);
        check("t2_empty", int'(empty), 1);
        check("t2_dout0", int'(dout), 0);

        // T3: 20 back-to-back toggles into a 16-deep FIFO
        for (int i = 0; i < 20; i++) begin
            toggle(8'(i));
            tick(0, 0);
            if (i == 15) begin
                check("t3_full", int'(full), 1);
                check("t3_count16", int'(count), 16);
                check("t3_ovf_pre", int'(overflow), 0);
            end
            if (i == 16) check("t3_ovf", int'(overflow), 1);
        end
        for (int i = 0; i < 16; i++) begin
            check("t3_drain", int'(dout), 'h200 | i);
            tick(1, 0);
        end
        check("t3_empty", int'(empty), 1);

        // T4: full FIFO, push and pop together
        tick(0, 1);
        check("t4_clr", int'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            toggle(8'(8'h20 + i));
            tick(0, 0);
        end
        toggle(8'h55);
        tick(1, 0);
        check("t4_count", int'(count), 16);
        check("t4_ovf", int'(overflow), 0);
        check("t4_head", int'(dout), 'h221);
        for (int i = 0; i < 15; i++) tick(1, 0);
        check("t4_tail", int'(dout), 'h255);
        tick(1, 0);
        check("t4_empty", int'(empty), 1);

        // T5: clr_ovf coincident with a drop loses to the set
        for (int i = 0; i < 17; i++) begin
            toggle(8'(8'h30 + i));
            tick(0, 0);
        end
        check("t5_ovf", int'(overflow), 1);
        toggle(8'h99);
        tick(0, 1);
        check("t5_ovf_hold", int'(overflow), 1);
        tick(0, 1);
        check("t5_ovf_clr", int'(overflow), 0);
        check("t5_count", int'(count), 16);

        // T6: reset mid-stream discards entries and re-arms
        reset = 1'b1;
        tick(0, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0);
            toggle(8'(8'h60 + i));
        end
        tick(0, 0);
        check("t6_q3", int'(count), 3);
        reset = 1'b1;
        tick(0, 0);
        check("t6_count", int'(count), 0);
        check("t6_empty", int'(empty), 1);
        reset = 1'b0;
        tick(0, 0);
        check("t6_arm", int'(count), 0);
        // Push into an empty FIFO with a coincident rd: pop ignored, push kept
        toggle(8'h77);
        tick(1, 0);
        check("t6_new", int'(count), 1);
        check("t6_dout", int'(dout), 'h277);
        tick(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
